stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/bcd_mod60.sv | 55 +++++
 rtl/stopwatch_counter.sv | 137 +++++++++++++
 tb/tb_stopwatch_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter: state encoding, parameter
// defaults and a counter-width helper.
package stopwatch_pkg;

  // Mode encoding is visible on the mode output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } sw_state_e;

  localparam int unsigned CLK_HZ_DEFAULT  = 1000;
  localparam int unsigned ADJ_DIV_DEFAULT = 500;
  localparam int unsigned MODE_W          = 2;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear and increment.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear, wins over inc_i
//   inc_i         : advance by one (59 wraps to 00)
//   ones_o/tens_o : registered BCD digits
//   carry_c_o     : combinational, high when inc_i wraps 59 -> 00
module bcd_mod60 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] ones_o,
  output logic [2:0] tens_o,
  output logic       carry_c_o
);

  logic [3:0] ones_q, ones_d;
  logic [2:0] tens_q, tens_d;
  logic       at_max_c;

  assign at_max_c  = (ones_q == 4'd9) && (tens_q == 3'd5);
  assign carry_c_o = inc_i && at_max_c;

  // Units roll 9 -> 0 and bump tens on the same edge; tens roll 5 -> 0.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr_i) begin
      ones_d = '0;
      tens_d = '0;
    end else if (inc_i) begin
      if (ones_q == 4'd9) begin
        ones_d = '0;
        tens_d = (tens_q == 3'd5) ? 3'd0 : tens_q + 3'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run / pause / adjust modes.
// Ports:
//   clk1KHz, rstN          : clock, async active-low reset
//   pause, clr, adj, sel   : debounced controls (sel: 0 = minutes, 1 = seconds)
//   secOnes..minTens       : registered BCD time digits
//   secTick                : registered one-cycle pulse per counted second
//   mode                   : registered state (RUN=0, PAUSE=1, ADJ=2)
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int unsigned ADJ_DIV = ADJ_DIV_DEFAULT
) (
  input  logic              clk1KHz,
  input  logic              rstN,
  input  logic              pause,
  input  logic              clr,
  input  logic              adj,
  input  logic              sel,
  output logic [3:0]        secOnes,
  output logic [2:0]        secTens,
  output logic [3:0]        minOnes,
  output logic [2:0]        minTens,
  output logic              secTick,
  output logic [MODE_W-1:0] mode
);

  localparam int unsigned PRESC_W = cnt_w(CLK_HZ);
  localparam int unsigned ADJ_W   = cnt_w(ADJ_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [ADJ_W-1:0]   ADJ_LAST   = ADJ_W'(ADJ_DIV - 1);

  sw_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [ADJ_W-1:0]   adj_cnt_q, adj_cnt_d;
  logic               sel_q;
  logic               sec_tick_q;

  logic tick_c;
  logic adj_inc_c;
  logic sel_chg_c;
  logic sec_inc_c;
  logic min_inc_c;
  logic sec_carry_c;
  logic min_carry_unused;

  // State register.
  always_ff @(posedge clk1KHz or negedge rstN) begin
    if (!rstN) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: adjust beats pause, otherwise pause level picks PAUSE/RUN.
  always_comb begin
    state_d = state_q;
    if (adj)        state_d = ST_ADJ;
    else if (pause) state_d = ST_PAUSE;
    else            state_d = ST_RUN;
  end

  // Per-state counter control; clr overrides everything below it.
  always_comb begin
    tick_c    = 1'b0;
    adj_inc_c = 1'b0;
    sel_chg_c = sel ^ sel_q;
    presc_d   = presc_q;
    adj_cnt_d = '0;
    case (state_q)
      ST_RUN: begin
        tick_c  = (presc_q == PRESC_LAST);
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
      end
      ST_PAUSE: begin
        presc_d = presc_q;
      end
      ST_ADJ: begin
        presc_d = '0;
        // A field switch restarts the adjust interval.
        if (sel_chg_c)                   adj_cnt_d = '0;
        else if (adj_cnt_q == ADJ_LAST)  adj_inc_c = 1'b1;
        else                             adj_cnt_d = adj_cnt_q + ADJ_W'(1);
      end
      default: begin
        presc_d = '0;
      end
    endcase
    if (clr) begin
      tick_c    = 1'b0;
      adj_inc_c = 1'b0;
      presc_d   = '0;
      adj_cnt_d = '0;
    end
  end

  // Seconds carry reaches minutes only on a running tick, never in adjust.
  assign sec_inc_c = tick_c | (adj_inc_c & sel);
  assign min_inc_c = (tick_c & sec_carry_c) | (adj_inc_c & ~sel);

  always_ff @(posedge clk1KHz or negedge rstN) begin
    if (!rstN) begin
      presc_q    <= '0;
      adj_cnt_q  <= '0;
      sel_q      <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      adj_cnt_q  <= adj_cnt_d;
      sel_q      <= sel;
      sec_tick_q <= tick_c;
    end
  end

  bcd_mod60 u_sec (
    .clk_i     (clk1KHz),
    .rst_ni    (rstN),
    .clr_i     (clr),
    .inc_i     (sec_inc_c),
    .ones_o    (secOnes),
    .tens_o    (secTens),
    .carry_c_o (sec_carry_c)
  );

  // Minutes wrap 59 -> 00 with nothing above them.
  bcd_mod60 u_min (
    .clk_i     (clk1KHz),
    .rst_ni    (rstN),
    .clr_i     (clr),
    .inc_i     (min_inc_c),
    .ones_o    (minOnes),
    .tens_o    (minTens),
    .carry_c_o (min_carry_unused)
  );

  assign secTick = sec_tick_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: a default-parameter instance for the real-time checks and
// a fast instance (CLK_HZ=10, ADJ_DIV=4) for long preloads. Both share inputs.
module tb_stopwatch_counter;

  logic clk, rst_n, pause, clr, adj, sel;

  logic [3:0] s_sec_ones, f_sec_ones, s_min_ones, f_min_ones;
  logic [2:0] s_sec_tens, f_sec_tens, s_min_tens, f_min_tens;
  logic       s_tick, f_tick;
  logic [1:0] s_mode, f_mode;
  logic [15:0] s_time, f_time;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ticks;
  int cyc;

  // Time packed as 16'hMMSS for readable expected values.
  assign s_time = {1'b0, s_min_tens, s_min_ones, 1'b0, s_sec_tens, s_sec_ones};
  assign f_time = {1'b0, f_min_tens, f_min_ones, 1'b0, f_sec_tens, f_sec_ones};

  stopwatch_counter u_dut (
    .clk1KHz (clk),        .rstN    (rst_n),      .pause   (pause),
    .clr     (clr),        .adj     (adj),        .sel     (sel),
    .secOnes (s_sec_ones), .secTens (s_sec_tens), .minOnes (s_min_ones),
    .minTens (s_min_tens), .secTick (s_tick),     .mode    (s_mode)
  );

  stopwatch_counter #(.CLK_HZ(10), .ADJ_DIV(4)) u_dut_fast (
    .clk1KHz (clk),        .rstN    (rst_n),      .pause   (pause),
    .clr     (clr),        .adj     (adj),        .sel     (sel),
    .secOnes (f_sec_ones), .secTens (f_sec_tens), .minOnes (f_min_ones),
    .minTens (f_min_tens), .secTick (f_tick),     .mode    (f_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cycles until secTick of the chosen instance; returns budget on timeout.
  task automatic wait_tick(input bit fast, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      step(1);
      cycles++;
      if ((fast ? f_tick : s_tick) === 1'b1) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; pause = 1'b0; clr = 1'b0; adj = 1'b0; sel = 1'b0;
    step(3);
    check("rst_time",   32'(s_time), 32'h0000);
    check("rst_tick",   32'(s_tick), 32'd0);
    check("rst_mode",   32'(s_mode), 32'd0);
    check("rst_f_time", 32'(f_time), 32'h0000);
    rst_n = 1'b1;

    // Free run: ticks on edges 1000, 2000, 3000 after release.
    n_ticks = 0;
    for (int k = 1; k <= 3000; k++) begin
      step(1);
      if (s_tick === 1'b1) begin
        n_ticks++;
        check("run_tick_pos", 32'(k), 32'(n_ticks * 1000));
      end
    end
    check("run_tick_cnt", 32'(n_ticks), 32'd3);
    check("run_time",     32'(s_time),  32'h0003);

    // 400 run cycles, long pause, then 600 more to the next second.
    step(400);
    pause = 1'b1;
    step(5000);
    check("pause_mode", 32'(s_mode), 32'd1);
    check("pause_hold", 32'(s_time), 32'h0003);
    check("pause_tick", 32'(s_tick), 32'd0);
    pause = 1'b0;
    wait_tick(1'b0, 1000, cyc);
    check("pause_release_lat", 32'(cyc),    32'd600);
    check("pause_resume_time", 32'(s_time), 32'h0004);

    // Adjust seconds: first bump 500 cycles after entry, then every 500.
    adj = 1'b1; sel = 1'b1;
    step(1);
    check("adj_mode", 32'(s_mode), 32'd2);
    step(499);
    check("adj_first_early", 32'(s_time), 32'h0004);
    step(1);
    check("adj_first_inc", 32'(s_time), 32'h0005);
    step(1000);
    check("adj_sec_plus3", 32'(s_time), 32'h0007);
    check("adj_no_tick",   32'(s_tick), 32'd0);

    // Fast instance: preload 00:59 then run into 01:00.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("f_clr", 32'(f_time), 32'h0000);
    step(236);
    check("f_pre_0059", 32'(f_time), 32'h0059);
    adj = 1'b0;
    wait_tick(1'b1, 20, cyc);
    check("f_run_lat",  32'(cyc),    32'd11);
    check("f_min_carry", 32'(f_time), 32'h0100);

    // Seconds to 59, then one minute bump leaves seconds at 59.
    adj = 1'b1; sel = 1'b1;
    step(237);
    check("f_pre_0159", 32'(f_time), 32'h0159);
    sel = 1'b0;
    step(4);
    check("f_sel_restart", 32'(f_time), 32'h0159);
    step(1);
    check("f_min_only", 32'(f_time), 32'h0259);
    step(228);
    check("f_pre_5959", 32'(f_time), 32'h5959);
    adj = 1'b0;
    wait_tick(1'b1, 20, cyc);
    check("f_wrap_lat",  32'(cyc),    32'd11);
    check("f_wrap_time", 32'(f_time), 32'h0000);

    // Preload 12:34, then clear on the edge that would tick.
    adj = 1'b1; sel = 1'b0;
    step(49);
    check("f_pre_1200", 32'(f_time), 32'h1200);
    sel = 1'b1;
    step(137);
    check("f_pre_1234", 32'(f_time), 32'h1234);
    adj = 1'b0;
    step(10);
    check("f_pre_clr_tick", 32'(f_tick), 32'd0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("f_clr_time", 32'(f_time), 32'h0000);
    check("f_clr_mode", 32'(f_mode), 32'd0);
    check("f_clr_tick", 32'(f_tick), 32'd0);
    wait_tick(1'b1, 20, cyc);
    check("f_after_clr_lat",  32'(cyc),    32'd10);
    check("f_after_clr_time", 32'(f_time), 32'h0001);

    // Reset mid-second between edges clears outputs without a clock edge.
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_f_time", 32'(f_time), 32'h0000);
    check("arst_f_mode", 32'(f_mode), 32'd0);
    check("arst_s_time", 32'(s_time), 32'h0000);
    check("arst_s_tick", 32'(s_tick), 32'd0);
    rst_n = 1'b1;
    wait_tick(1'b1, 20, cyc);
    check("arst_restart_lat",  32'(cyc),    32'd10);
    check("arst_restart_time", 32'(f_time), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
